// File: rtl/sophon_pkg.sv
// Shared types and constants for the SOPHON end-of-test monitor.
// Provides the per-hart FSM state encoding and the default gp pass code.
// No ports; imported by sim_finish_hart and sim_finish_monitor.
package sophon_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        FIN   = 2'd2
    } hart_state_t;

    localparam logic [31:0] DEFAULT_PASS_CODE = 32'd1;

    // Width of the per-hart drain counter; bounds DRAIN_CYCLES to 2^16-1.
    localparam int DRAIN_W = 16;

endpackage

// File: rtl/sim_finish_hart.sv
// Per-hart end-of-test tracker: ecall -> drain for DRAIN_CYCLES -> sample gp.
// Ports: clk_i/rst_i (async active-high), en_i (advance enable), ecall_i,
//        gp_i[31:0], done_o (verdict reached), fail_o (gp != PASS_CODE).
module sim_finish_hart
    import sophon_pkg::*;
#(
    parameter int          DRAIN_CYCLES = 255,
    parameter logic [31:0] PASS_CODE    = DEFAULT_PASS_CODE
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic        ecall_i,
    input  logic [31:0] gp_i,
    output logic        done_o,
    output logic        fail_o
);

    localparam logic [DRAIN_W-1:0] LP_DRAIN_END = DRAIN_W'(DRAIN_CYCLES);

    hart_state_t        r_state;
    logic [DRAIN_W-1:0] r_drain_cnt;
    logic               r_done;
    logic               r_fail;

    hart_state_t        w_state_nxt;
    logic [DRAIN_W-1:0] w_drain_cnt_nxt;
    logic               w_done_nxt;
    logic               w_fail_nxt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= RUN;
            r_drain_cnt <= '0;
            r_done      <= 1'b0;
            r_fail      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_cnt_nxt;
            r_done      <= w_done_nxt;
            r_fail      <= w_fail_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_drain_cnt_nxt = r_drain_cnt;
        w_done_nxt      = r_done;
        w_fail_nxt      = r_fail;
        if (en_i) begin
            case (r_state)
                RUN: begin
                    if (ecall_i) begin
                        w_state_nxt     = DRAIN;
                        w_drain_cnt_nxt = DRAIN_W'(1);
                    end
                end
                DRAIN: begin
                    // Further ecalls are ignored here; only the first one
                    // starts the drain window. gp is looked at only now.
                    if (r_drain_cnt == LP_DRAIN_END) begin
                        w_state_nxt = FIN;
                        w_done_nxt  = 1'b1;
                        w_fail_nxt  = (gp_i != PASS_CODE);
                    end else begin
                        w_drain_cnt_nxt = r_drain_cnt + DRAIN_W'(1);
                    end
                end
                default: begin
                    // FIN is terminal until reset.
                end
            endcase
        end
    end

    assign done_o = r_done;
    assign fail_o = r_fail;

endmodule

// File: rtl/sim_finish_monitor.sv
// End-of-test monitor: per-hart ecall/gp verdicts aggregated with a global timeout.
// Ports: clk_i/rst_i (async active-high), en_i, ecall_i[NUM_HART], gp_i[32*NUM_HART];
//        hart_done_o, fail_mask_o, done_o/pass_o/timeout_o (sticky), cycle_cnt_o.
// Macro SOPHON_FINISH_MSG_EN adds a simulation-only verdict print and $finish.
module sim_finish_monitor
    import sophon_pkg::*;
#(
    parameter int          NUM_HART     = 1,
    parameter int          TO_BIT       = 18,
    parameter int          DRAIN_CYCLES = 255,
    parameter logic [31:0] PASS_CODE    = DEFAULT_PASS_CODE
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   en_i,
    input  logic [NUM_HART-1:0]    ecall_i,
    input  logic [32*NUM_HART-1:0] gp_i,
    output logic [NUM_HART-1:0]    hart_done_o,
    output logic [NUM_HART-1:0]    fail_mask_o,
    output logic                   done_o,
    output logic                   pass_o,
    output logic                   timeout_o,
    output logic [TO_BIT-1:0]      cycle_cnt_o
);

    logic [TO_BIT-1:0]   r_cycle_cnt;
    logic                r_done;
    logic                r_pass;
    logic                r_timeout;

    logic [NUM_HART-1:0] w_hart_done;
    logic [NUM_HART-1:0] w_fail_mask;
    logic                w_run_en;
    logic                w_all_done;
    logic                w_cnt_max;

    // Once the global verdict is latched everything freezes, so the harts
    // and the counter share one gated enable.
    assign w_run_en   = en_i & ~r_done;
    assign w_all_done = &w_hart_done;
    assign w_cnt_max  = &r_cycle_cnt;

    for (genvar h = 0; h < NUM_HART; h++) begin : g_hart
        sim_finish_hart #(
            .DRAIN_CYCLES (DRAIN_CYCLES),
            .PASS_CODE    (PASS_CODE)
        ) u_hart (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .en_i    (w_run_en),
            .ecall_i (ecall_i[h]),
            .gp_i    (gp_i[32*h +: 32]),
            .done_o  (w_hart_done[h]),
            .fail_o  (w_fail_mask[h])
        );
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cycle_cnt <= '0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            if (w_run_en && !w_cnt_max) begin
                r_cycle_cnt <= r_cycle_cnt + TO_BIT'(1);
            end
            // Hart completion takes priority over a simultaneous saturation.
            if (!r_done && (w_all_done || w_cnt_max)) begin
                r_done    <= 1'b1;
                r_pass    <= w_all_done & ~|w_fail_mask;
                r_timeout <= ~w_all_done;
            end
        end
    end

    assign hart_done_o = w_hart_done;
    assign fail_mask_o = w_fail_mask;
    assign done_o      = r_done;
    assign pass_o      = r_pass;
    assign timeout_o   = r_timeout;
    assign cycle_cnt_o = r_cycle_cnt;

`ifdef SOPHON_FINISH_MSG_EN
    // Runs on the first clock after done_o rises, when every status register
    // has settled and is frozen.
    always @(posedge clk_i) begin
        if (r_done) begin
            if (r_timeout) begin
                $display("[%0t] sim_finish_monitor: TIMEOUT", $realtime);
            end else if (r_pass) begin
                $display("[%0t] sim_finish_monitor: PASS", $realtime);
            end else begin
                $display("[%0t] sim_finish_monitor: FAIL", $realtime);
                for (int h = 0; h < NUM_HART; h++) begin
                    if (w_fail_mask[h]) begin
                        $display("  hart %0d gp=0x%08h", h, gp_i[32*h +: 32]);
                    end
                end
            end
            $finish;
        end
    end
`endif

endmodule
